// File: rtl/gshare_bht.sv
// gshare_bht: gshare conditional-branch predictor with per-lane counters and a speculative GHR
module gshare_bht #(
    parameter int NrEntries = 128,
    parameter int Lanes     = 2,
    parameter int HistLen   = 3,
    parameter int CtrWidth  = 2,
    parameter int VLEN      = 64,
    localparam int Rows     = NrEntries / Lanes,
    localparam int IdxBits  = $clog2(Rows),
    localparam int LaneBits = $clog2(Lanes),
    localparam int GW       = (HistLen > 0) ? HistLen : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_bp_i,
    input  logic            debug_mode_i,
    input  logic [VLEN-1:0] vpc_i,
    output logic [Lanes-1:0] pred_valid_o,
    output logic [Lanes-1:0] pred_taken_o,
    output logic [GW-1:0]   ghr_o,
    input  logic            spec_push_i,
    input  logic            spec_taken_i,
    input  logic            upd_valid_i,
    input  logic [VLEN-1:0] upd_pc_i,
    input  logic [GW-1:0]   upd_ghr_i,
    input  logic            upd_taken_i,
    input  logic            upd_mispredict_i
);
    localparam int EW = $clog2(NrEntries);
    localparam int LB = (LaneBits > 0) ? LaneBits : 1;
    localparam logic [CtrWidth-1:0] WeakT  = CtrWidth'(1) << (CtrWidth - 1);
    localparam logic [CtrWidth-1:0] WeakN  = WeakT - CtrWidth'(1);
    localparam logic [CtrWidth-1:0] CtrMax = '1;

    // Entries are flattened as {row, lane}, so one row's lanes sit next to each other.
    logic [NrEntries-1:0] valid_q;
    logic [CtrWidth-1:0]  ctr_q [NrEntries];
    logic [GW-1:0]        ghr_q, ghr_d;
    logic [IdxBits-1:0]   hist_lk, hist_up, row_lk, row_up;
    logic [LB-1:0]        lane_up;
    logic [EW-1:0]        base_lk, idx_up;
    logic [CtrWidth-1:0]  ctr_cur, ctr_d;
    logic                 upd_en, mispred_en;
    logic                 unused_bits;

    // Only the row/lane slices of the PCs matter; the rest is intentionally ignored.
    assign unused_bits = ^{vpc_i, upd_pc_i, upd_ghr_i};

    assign upd_en     = upd_valid_i && !debug_mode_i;
    assign mispred_en = upd_en && upd_mispredict_i;
    assign ghr_o      = ghr_q;

    // Hash: GHR zero-extended into the row LSBs; a zero-length history degenerates to bimodal.
    always_comb begin
        hist_lk = (HistLen == 0) ? '0 : IdxBits'(ghr_q);
        hist_up = (HistLen == 0) ? '0 : IdxBits'(upd_ghr_i);
        row_lk  = vpc_i[1+LaneBits +: IdxBits] ^ hist_lk;
        row_up  = upd_pc_i[1+LaneBits +: IdxBits] ^ hist_up;
        lane_up = (Lanes > 1) ? upd_pc_i[1 +: LB] : '0;
        base_lk = EW'(row_lk) << LaneBits;
        idx_up  = (EW'(row_up) << LaneBits) | EW'(lane_up);
    end

    // Zero-latency lookup of every lane in the selected row; taken only counts on a valid entry.
    always_comb begin
        pred_valid_o = '0;
        pred_taken_o = '0;
        for (int l = 0; l < Lanes; l++) begin
            pred_valid_o[l] = valid_q[base_lk | EW'(l)];
            pred_taken_o[l] = valid_q[base_lk | EW'(l)] & ctr_q[base_lk | EW'(l)][CtrWidth-1];
        end
    end

    // Next counter value: fresh entries start weak in the resolved direction, others saturate.
    always_comb begin
        ctr_cur = ctr_q[idx_up];
        ctr_d   = !valid_q[idx_up] ? (upd_taken_i ? WeakT : WeakN)
                : upd_taken_i      ? ((ctr_cur == CtrMax) ? ctr_cur : ctr_cur + CtrWidth'(1))
                :                    ((ctr_cur == '0) ? ctr_cur : ctr_cur - CtrWidth'(1));
    end

    // GHR next state: flush, then mispredict restore (drops a same-cycle push), then speculative push.
    always_comb begin
        ghr_d = ghr_q;
        if (flush_bp_i) ghr_d = '0;
        else if (mispred_en) ghr_d = GW'({upd_ghr_i, upd_taken_i});
        else if (spec_push_i && !debug_mode_i) ghr_d = GW'({ghr_q, spec_taken_i});
        if (HistLen == 0) ghr_d = '0;
    end

    // Table storage: whole-table clear on reset or flush, otherwise single-entry write-back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_bp_i) begin
            valid_q <= '0;
            for (int i = 0; i < NrEntries; i++) ctr_q[i] <= '0;
        end else if (upd_en) begin
            valid_q[idx_up] <= 1'b1;
            ctr_q[idx_up]   <= ctr_d;
        end
    end

    // GHR register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ghr_q <= '0;
        else ghr_q <= ghr_d;
    end
endmodule

// File: tb/tb_gshare_bht.sv
// tb_gshare_bht: directed and randomized checks of gshare_bht against a behavioural model
module tb_gshare_bht;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_bp_i = 1'b0;
    logic        debug_mode_i = 1'b0;
    logic [63:0] vpc_i = '0;
    logic [1:0]  pred_valid_o, pred_taken_o;
    logic [2:0]  ghr_o;
    logic        spec_push_i = 1'b0;
    logic        spec_taken_i = 1'b0;
    logic        upd_valid_i = 1'b0;
    logic [63:0] upd_pc_i = '0;
    logic [2:0]  upd_ghr_i = '0;
    logic        upd_taken_i = 1'b0;
    logic        upd_mispredict_i = 1'b0;

    int checks = 0;
    int errors = 0;

    bit m_vld [128];
    int m_ctr [128];
    int m_ghr = 0;

    gshare_bht dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
        .vpc_i(vpc_i), .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .ghr_o(ghr_o),
        .spec_push_i(spec_push_i), .spec_taken_i(spec_taken_i), .upd_valid_i(upd_valid_i),
        .upd_pc_i(upd_pc_i), .upd_ghr_i(upd_ghr_i), .upd_taken_i(upd_taken_i),
        .upd_mispredict_i(upd_mispredict_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entry number = row * 2 + lane, with row = (pc/4 mod 64) xor history.
    function automatic int entry(input logic [63:0] pc, input int g);
        return ((int'((pc / 4) % 64) ^ g) * 2) + int'((pc / 2) % 2);
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 128; i++) begin
            m_vld[i] = 1'b0;
            m_ctr[i] = 0;
        end
        m_ghr = 0;
    endfunction

    // Behavioural model of the predictor state.
    always @(posedge clk_i or posedge rst_i) begin
        int ng;
        int e;
        if (rst_i || flush_bp_i) m_clear();
        else begin
            ng = m_ghr;
            if (upd_valid_i && !debug_mode_i) begin
                e = entry(upd_pc_i, int'(upd_ghr_i));
                if (!m_vld[e]) begin
                    m_vld[e] = 1'b1;
                    m_ctr[e] = upd_taken_i ? 2 : 1;
                end else if (upd_taken_i) m_ctr[e] = (m_ctr[e] < 3) ? m_ctr[e] + 1 : 3;
                else m_ctr[e] = (m_ctr[e] > 0) ? m_ctr[e] - 1 : 0;
            end
            if (upd_valid_i && upd_mispredict_i && !debug_mode_i)
                ng = (int'(upd_ghr_i) * 2 + int'(upd_taken_i)) % 8;
            else if (spec_push_i && !debug_mode_i)
                ng = (m_ghr * 2 + int'(spec_taken_i)) % 8;
            m_ghr = ng;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        logic [1:0] ev, et;
        int e;
        for (int l = 0; l < 2; l++) begin
            e = entry(vpc_i & ~64'h2, m_ghr) + l;
            ev[l] = m_vld[e];
            et[l] = m_vld[e] && (m_ctr[e] >= 2);
        end
        chk("model_valid", int'(pred_valid_o), int'(ev));
        chk("model_taken", int'(pred_taken_o), int'(et));
        chk("model_ghr", int'(ghr_o), m_ghr);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [63:0] pc, input logic [2:0] g, input logic t, input logic m);
        upd_valid_i = 1'b1;
        upd_pc_i = pc;
        upd_ghr_i = g;
        upd_taken_i = t;
        upd_mispredict_i = m;
        tick();
        upd_valid_i = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    task automatic push(input logic t);
        spec_push_i = 1'b1;
        spec_taken_i = t;
        tick();
        spec_push_i = 1'b0;
    endtask

    task automatic look(input logic [63:0] pc);
        vpc_i = pc;
        #1;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        look(64'h8000_0010);
        chk("reset_valid", int'(pred_valid_o), 0);
        chk("reset_taken", int'(pred_taken_o), 0);
        chk("reset_ghr", int'(ghr_o), 0);
        upd(64'h8000_0010, 3'd0, 1'b1, 1'b0);
        upd(64'h8000_0010, 3'd0, 1'b1, 1'b0);
        look(64'h8000_0010);
        chk("first_valid", int'(pred_valid_o), 1);
        chk("first_taken", int'(pred_taken_o), 1);
        push(1'b1);
        push(1'b0);
        push(1'b1);
        chk("hist_ghr", int'(ghr_o), 5);
        look(64'h8000_0004);
        chk("hash_valid", int'(pred_valid_o), 1);
        chk("hash_taken", int'(pred_taken_o), 1);
        repeat (3) push(1'b0);
        chk("hist_zero_ghr", int'(ghr_o), 0);
        look(64'h8000_0004);
        chk("nohash_valid", int'(pred_valid_o), 0);
        spec_push_i = 1'b1;
        spec_taken_i = 1'b1;
        upd(64'h0000_0200, 3'b011, 1'b0, 1'b1);
        spec_push_i = 1'b0;
        chk("restore_ghr", int'(ghr_o), 6);
        look(64'h8000_0008);
        chk("sat_start", int'(pred_taken_o), 1);
        upd(64'h8000_0010, 3'd0, 1'b0, 1'b0);
        chk("sat_10", int'(pred_taken_o), 1);
        upd(64'h8000_0010, 3'd0, 1'b0, 1'b0);
        chk("sat_01", int'(pred_taken_o), 0);
        upd(64'h8000_0010, 3'd0, 1'b0, 1'b0);
        chk("sat_00", int'(pred_taken_o), 0);
        upd(64'h8000_0010, 3'd0, 1'b0, 1'b0);
        chk("sat_hold", int'(pred_taken_o), 0);
        upd(64'h8000_0010, 3'd0, 1'b1, 1'b0);
        chk("sat_up01", int'(pred_taken_o), 0);
        upd(64'h8000_0010, 3'd0, 1'b1, 1'b0);
        chk("sat_up10", int'(pred_taken_o), 1);
        chk("sat_valid", int'(pred_valid_o), 1);
        flush_bp_i = 1'b1;
        upd(64'h8000_0040, 3'd0, 1'b1, 1'b0);
        flush_bp_i = 1'b0;
        chk("flush_ghr", int'(ghr_o), 0);
        look(64'h8000_0040);
        chk("flush_upd_dropped", int'(pred_valid_o), 0);
        look(64'h8000_0010);
        chk("flush_cleared", int'(pred_valid_o), 0);
        debug_mode_i = 1'b1;
        spec_push_i = 1'b1;
        spec_taken_i = 1'b1;
        upd(64'h8000_0010, 3'd0, 1'b1, 1'b1);
        spec_push_i = 1'b0;
        debug_mode_i = 1'b0;
        chk("debug_ghr", int'(ghr_o), 0);
        chk("debug_valid", int'(pred_valid_o), 0);
        upd(64'h8000_0010, 3'd0, 1'b1, 1'b0);
        push(1'b1);
        look(64'h8000_0014);
        chk("pre_rst_valid", int'(pred_valid_o), 1);
        chk("pre_rst_taken", int'(pred_taken_o), 1);
        chk("pre_rst_ghr", int'(ghr_o), 1);
        upd_valid_i = 1'b1;
        upd_pc_i = 64'h8000_0014;
        upd_ghr_i = 3'd1;
        upd_taken_i = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid", int'(pred_valid_o), 0);
        chk("arst_taken", int'(pred_taken_o), 0);
        chk("arst_ghr", int'(ghr_o), 0);
        tick();
        tick();
        rst_i = 1'b0;
        upd_valid_i = 1'b0;
        #1;
        chk("post_rst_valid", int'(pred_valid_o), 0);
        chk("post_rst_ghr", int'(ghr_o), 0);
        for (int c = 0; c < 3000; c++) begin
            vpc_i = 64'h8000_0000 | (64'($urandom_range(0, 127)) << 1);
            upd_pc_i = 64'h8000_0000 | (64'($urandom_range(0, 127)) << 1);
            upd_valid_i = ($urandom_range(0, 1) == 1);
            upd_ghr_i = 3'($urandom_range(0, 7));
            upd_taken_i = ($urandom_range(0, 1) == 1);
            upd_mispredict_i = ($urandom_range(0, 3) == 0);
            spec_push_i = ($urandom_range(0, 1) == 1);
            spec_taken_i = ($urandom_range(0, 1) == 1);
            debug_mode_i = ($urandom_range(0, 7) == 0);
            flush_bp_i = ($urandom_range(0, 63) == 0);
            rst_i = ($urandom_range(0, 255) == 0);
            tick();
        end
        {upd_valid_i, spec_push_i, debug_mode_i, flush_bp_i, rst_i} = '0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gshare_bht.md
Name: gshare_bht

Overview:
- Parametrised successor to the current per-PC branch history table: a gshare conditional-branch predictor.
- The row index is the fetch PC XORed with a speculative global history register (GHR) of configurable length.
- Supports multiple instructions per fetch row, GHR snapshot/restore on mispredict, and single-cycle clear.
- Sits in the frontend next to the BTB and RAS; it is fed by frontend lookups and by branch-unit resolutions.

Parameters:
- NrEntries, 128, total counters; power of 2, at least 2*Lanes.
- Lanes, 2, instructions per fetch row (RVC granularity); power of 2.
- HistLen, 3, GHR bits; range 0..IdxBits. 0 gives a plain bimodal table.
- CtrWidth, 2, saturating counter width (at least 1).
- VLEN, 64, virtual address width.
- Derived: Rows=NrEntries/Lanes; IdxBits=log2(Rows); LaneBits=log2(Lanes); GW=max(HistLen,1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- flush_bp_i  in  1  clear all entries and the GHR.
- debug_mode_i  in  1  block table and GHR updates.
- vpc_i  in  VLEN  lookup PC.
- pred_valid_o  out  Lanes  per-lane entry valid.
- pred_taken_o  out  Lanes  per-lane prediction.
- ghr_o  out  GW  speculative GHR used for the current lookup (snapshot).
- spec_push_i  in  1  frontend committed a conditional-branch prediction.
- spec_taken_i  in  1  direction pushed into the GHR.
- upd_valid_i  in  1  branch resolution valid.
- upd_pc_i  in  VLEN  resolved branch PC.
- upd_ghr_i  in  GW  snapshot captured at that branch's prediction.
- upd_taken_i  in  1  actual outcome.
- upd_mispredict_i  in  1  direction mispredicted.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst_i is high, all valid bits, counters and the GHR clear immediately. Outputs settle to pred_valid_o=0, pred_taken_o=0, ghr_o=0.
- Indexing: row = pc[1+LaneBits +: IdxBits] XOR zero-extended GHR (GHR in the row LSBs); lane = pc[1 +: LaneBits].
  - Lookup uses vpc_i with the speculative GHR. Update uses upd_pc_i with upd_ghr_i.
  - HistLen=0: the XOR term is 0 and ghr_o is tied 0.
- Lookup is combinational, 0-cycle. For each lane l: pred_valid_o[l]=valid[row][l]; pred_taken_o[l]=counter MSB, qualified by valid. No bypass: an update in the same cycle to the same entry is visible from the next cycle.
- Update (upd_valid_i & !debug_mode_i) is a registered read-modify-write of one entry, taking effect next cycle.
  - Invalid entry: set valid; counter initialises to weak taken (100..0 pattern MSB=1, rest 0) if taken, else weak not-taken (011..1).
  - Valid entry: increment on taken, saturating at all-ones; decrement on not-taken, saturating at 0.
- GHR shift: new = {ghr[HistLen-2:0], bit}. For HistLen=1, new = bit.
- GHR priority, per cycle:
  1. flush_bp_i: GHR=0.
  2. Otherwise upd_valid_i & upd_mispredict_i & !debug_mode_i: GHR = shift(upd_ghr_i, upd_taken_i). spec_push_i in the same cycle is dropped.
  3. Otherwise spec_push_i & !debug_mode_i: GHR = shift(GHR, spec_taken_i).
  4. Otherwise hold.
- flush_bp_i: in one cycle, clears all valid bits and counters and the GHR. It has priority over a same-cycle update.
- debug_mode_i high: no state changes except flush and reset; lookups still return table contents.
- Reset mid-operation: any in-flight update is lost. The table restarts empty on the first edge after rst_i deasserts.
- Storage is flops, NrEntries*(CtrWidth+1) bits. No SRAM and no multi-cycle clear.

Test Plan:
All scenarios use the defaults (Rows=64, IdxBits=6, HistLen=3).
- Reset/first update: after reset, vpc=0x8000_0010 -> pred_valid_o=2'b00, ghr_o=0. Then update pc=0x8000_0010, ghr=0, taken, twice -> row 4, lane 0 counter 2'b11; lookup gives pred_valid_o[0]=1, pred_taken_o[0]=1.
- Gshare hashing: spec pushes T,N,T -> ghr_o=3'b101. Lookup vpc=0x8000_0004 (row 1^5=4) -> hits the entry above, pred_taken_o[0]=1. The same vpc with GHR=0 -> pred_valid_o=0.
- Mispredict restore: upd_ghr=3'b011, taken=0, mispredict=1, with spec_push_i=1 in the same cycle -> next-cycle ghr_o=3'b110 (push dropped).
- Saturation: counter 2'b11 plus 3 not-taken updates -> 10, 01, 00 (prediction turns not-taken after the second). A fourth update stays 00.
- Flush priority: flush_bp_i and an update in the same cycle -> next cycle all pred_valid_o=0, ghr_o=0, and the update is not applied.
- Debug and async reset: debug_mode_i=1 with update and push -> no change. Assert rst_i mid-cycle during an update -> outputs drop to 0 before the next clock edge, and the table is empty afterwards.
